// File: rtl/bus_pkg.sv
// Shared types and address-window helpers for the bus fabric.
package bus_pkg;

  localparam int unsigned MAX_EP = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] range;
  } addr_range_t;

  // Index width for n endpoints, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One bit per window: base <= addr < base + range, evaluated one bit wider
  // than the operands so base + range cannot wrap.
  function automatic logic [MAX_EP-1:0] hit_vec(input logic [31:0]  addr,
                                                input addr_range_t  win [MAX_EP],
                                                input int unsigned  n);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    hit_vec = '0;
    a = {1'b0, addr};
    for (int unsigned i = 0; i < MAX_EP; i++) begin
      lo = {1'b0, win[i].base};
      hi = {1'b0, win[i].base} + {1'b0, win[i].range};
      if (i < n) hit_vec[i] = (a >= lo) && (a < hi);
    end
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational address decoder: lowest-index hit, its index and its offset.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned NUM_EP         = 2,
  parameter int unsigned BASES  [NUM_EP] = '{0, 16},
  parameter int unsigned RANGES [NUM_EP] = '{4, 8}
) (
  input  logic [ADDR_WIDTH-1:0]        h_addr,
  output logic                         hit,
  output logic [idx_w(NUM_EP)-1:0]     idx,
  output logic [ADDR_WIDTH-1:0]        offset
);

  addr_range_t       win [MAX_EP];
  logic [MAX_EP-1:0] hits;

  // Build the window table and pick the first matching endpoint.
  always_comb begin
    win = '{default: '0};
    for (int unsigned i = 0; i < NUM_EP; i++) begin
      win[i].base  = 32'(BASES[i]);
      win[i].range = 32'(RANGES[i]);
    end
    hits   = hit_vec(32'(h_addr), win, NUM_EP);
    hit    = |hits;
    idx    = '0;
    offset = '0;
    for (int unsigned i = NUM_EP; i > 0; i--) begin
      // Scanning downward lets the lowest matching index win on overlap.
      if (hits[i-1]) begin
        idx    = (idx_w(NUM_EP))'(i - 1);
        offset = h_addr - ADDR_WIDTH'(BASES[i-1]);
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Clocked host-to-endpoint interconnect with req/ack handshake,
// one-hot endpoint select, registered read mux and error responses.
module bus_fabric
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned DATA_WIDTH     = 4,
  parameter int unsigned NUM_EP         = 2,
  parameter int unsigned BASES  [NUM_EP] = '{0, 16},
  parameter int unsigned RANGES [NUM_EP] = '{4, 8},
  parameter int unsigned TIMEOUT        = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         h_req,
  input  logic                         h_r_wn,
  input  logic [ADDR_WIDTH-1:0]        h_addr,
  input  logic [DATA_WIDTH-1:0]        h_wdata,
  output logic                         h_ack,
  output logic                         h_err,
  output logic [DATA_WIDTH-1:0]        h_rdata,
  output logic                         h_busy,
  output logic [NUM_EP-1:0]            ep_sel,
  output logic                         ep_r_wn,
  output logic [ADDR_WIDTH-1:0]        ep_addr,
  output logic [DATA_WIDTH-1:0]        ep_wdata,
  input  logic [NUM_EP*DATA_WIDTH-1:0] ep_rdata,
  input  logic [NUM_EP-1:0]            ep_ack
);

  localparam int unsigned IDX_W = idx_w(NUM_EP);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic                    dec_hit;
  logic [IDX_W-1:0]        dec_idx;
  logic [ADDR_WIDTH-1:0]   dec_off;
  logic [IDX_W-1:0]        sel_idx;
  logic [CNT_W-1:0]        cnt;
  logic                    sel_ack;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    go_hit, go_miss, done_ack, done_to;

  bus_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_EP     (NUM_EP),
    .BASES      (BASES),
    .RANGES     (RANGES)
  ) u_decode (
    .h_addr (h_addr),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_off)
  );

  assign sel_ack   = ep_ack[sel_idx];
  assign sel_rdata = ep_rdata[sel_idx*DATA_WIDTH +: DATA_WIDTH];
  assign h_ack     = (state_q == RESP);
  assign h_busy    = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and transaction strobes; ack beats timeout in the same cycle.
  always_comb begin
    state_d  = state_q;
    go_hit   = 1'b0;
    go_miss  = 1'b0;
    done_ack = 1'b0;
    done_to  = 1'b0;
    case (state_q)
      IDLE: begin
        if (h_req) begin
          if (dec_hit) begin
            go_hit  = 1'b1;
            state_d = ACCESS;
          end else begin
            go_miss = 1'b1;
            state_d = RESP;
          end
        end
      end
      ACCESS: begin
        if (sel_ack) begin
          done_ack = 1'b1;
          state_d  = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          done_to = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers driven by the transaction strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      ep_sel   <= '0;
      ep_addr  <= '0;
      ep_r_wn  <= 1'b0;
      ep_wdata <= '0;
      sel_idx  <= '0;
      cnt      <= '0;
      h_err    <= 1'b0;
      h_rdata  <= '0;
    end else begin
      if (go_hit) begin
        ep_sel   <= NUM_EP'(1) << dec_idx;
        ep_addr  <= dec_off;
        ep_r_wn  <= h_r_wn;
        ep_wdata <= h_wdata;
        sel_idx  <= dec_idx;
        cnt      <= '0;
      end
      if (go_miss) begin
        h_err   <= 1'b1;
        h_rdata <= '0;
      end
      if (state_q == ACCESS && !done_ack && !done_to) cnt <= cnt + 1'b1;
      if (done_ack) begin
        ep_sel  <= '0;
        h_err   <= 1'b0;
        h_rdata <= ep_r_wn ? sel_rdata : '0;
      end
      if (done_to) begin
        ep_sel  <= '0;
        h_err   <= 1'b1;
        h_rdata <= '0;
      end
      if (state_q == RESP) begin
        h_err   <= 1'b0;
        h_rdata <= '0;
      end
    end
  end

endmodule

// File: doc/bus_fabric.md
Name: bus_fabric

Overview:
- Clocked, parametrised interconnect between one bus host and NUM_EP memory-mapped endpoints.
- Successor to the unclocked shared-bus with OR'd read data: adds a request/acknowledge handshake, one-hot endpoint select, base-relative endpoint addressing, registered read-data mux, and error responses for unmapped addresses and endpoint timeouts.
- Sits between bus_host and the bus_endpoint instances.

Parameters:
- ADDR_WIDTH, 5, host address width.
- DATA_WIDTH, 4, data width.
- NUM_EP, 2, number of endpoints (1..16).
- BASES, '{0,16}, per-endpoint base address, NUM_EP entries.
- RANGES, '{4,8}, per-endpoint window size in words, NUM_EP entries.
- TIMEOUT, 15, maximum cycles in ACCESS before error (>=1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- h_req  in  1  host request; held until h_ack.
- h_r_wn  in  1  1=read, 0=write.
- h_addr  in  ADDR_WIDTH  host address.
- h_wdata  in  DATA_WIDTH  write data.
- h_ack  out  1  one-cycle completion pulse.
- h_err  out  1  error flag, valid only with h_ack.
- h_rdata  out  DATA_WIDTH  read data, valid with h_ack.
- h_busy  out  1  high in ACCESS and RESP.
- ep_sel  out  NUM_EP  one-hot endpoint select.
- ep_r_wn  out  1  registered copy of h_r_wn.
- ep_addr  out  ADDR_WIDTH  h_addr - BASES[i].
- ep_wdata  out  DATA_WIDTH  registered write data.
- ep_rdata  in  NUM_EP*DATA_WIDTH  endpoint read data, slice i = endpoint i.
- ep_ack  in  NUM_EP  endpoint completion, one bit per endpoint.

Behaviour:
- Decode: endpoint i hits when BASES[i] <= h_addr < BASES[i]+RANGES[i].
  - Upper bound is exclusive.
  - Compare at ADDR_WIDTH+1 bits so the upper bound does not wrap.
  - Overlapping windows: lowest index wins.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, h_req=1 with a hit -> ACCESS. On the same edge register:
  - ep_sel = 1<<i
  - ep_addr = offset
  - ep_r_wn, ep_wdata
  - timeout counter cleared to 0.
- IDLE, h_req=1 with a miss -> RESP with h_err=1, h_rdata=0. ep_sel stays 0.
- ACCESS, ep_ack[i]=1 for the selected i -> RESP.
  - Capture the ep_rdata slice i into h_rdata on a read, 0 on a write.
  - h_err=0.
  - ep_sel cleared.
- ACCESS, no ack -> counter increments. When the counter reaches TIMEOUT-1 without an ack -> RESP with h_err=1, h_rdata=0, ep_sel cleared.
  - An ack arriving in that same cycle takes priority over the timeout.
- RESP: h_ack=1 for exactly one cycle, then -> IDLE.
  - h_req is ignored in RESP.
  - The host must drop h_req the cycle after h_ack. A new request is accepted from IDLE on the following edge.
- Latency:
  - Hit: ep_sel rises 1 cycle after req is sampled; h_ack rises 1 cycle after ep_ack is sampled.
  - Miss: h_ack 1 cycle after req.
- ep_ack bits of non-selected endpoints are ignored in every state. ep_ack in IDLE/RESP is ignored.
- h_addr, h_r_wn and h_wdata are sampled only on the IDLE->ACCESS/RESP edge. Later changes have no effect.
- Reset:
  - All outputs 0, state IDLE, counter 0.
  - rst asserted mid-transaction aborts it: no h_ack is ever issued for that transaction, and ep_sel drops on the next edge.

Decomposition:
- Package bus_pkg:
  - state_t enum (IDLE, ACCESS, RESP)
  - addr-range struct type (base, range)
  - function returning a hit vector for an address against a range array.
- Sub-module bus_addr_decode, purely combinational:
  - Inputs: h_addr, BASES, RANGES.
  - Outputs: hit flag, encoded index, offset.
  - Instantiated once in bus_fabric.

Test Plan (defaults; ep model acks after N cycles):
- Write: addr 2, wdata 4'hA -> ep_sel=2'b01, ep_addr=2, ep_wdata=4'hA one cycle after req. ep0 acks 3 cycles later -> h_ack next cycle, h_err=0.
- Read: addr 18 -> ep_sel=2'b10, ep_addr=2. ep1 drives 4'h5 with ack -> h_rdata=4'h5, h_err=0.
- Boundaries:
  - addr 3 -> ep0 offset 3; addr 4 -> h_ack+h_err 1 cycle after req, ep_sel never asserted.
  - addr 23 -> ep1 offset 7; addr 24 and addr 31 -> error.
- Timeout: read addr 1, ep0 never acks -> h_ack with h_err=1, h_rdata=0 after 15 cycles in ACCESS. ep_sel drops on the RESP edge.
- Stray ack: during an ep0 access, pulse ep_ack=2'b10 for 2 cycles -> no h_ack. A later ep_ack[0] completes the transaction normally.
- Reset: assert rst for 1 cycle while in ACCESS -> next cycle all outputs 0, h_busy=0, no h_ack. A fresh read of addr 16 then completes normally.
